// File: rtl/trap_controller.sv
// trap_controller: trap entry/return sequencer with mepc/mcause/mtval capture; optional counter under TRAP_COUNT_EN
module trap_controller #(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] TEXT_BASE    = 32'h0008_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [3:0]  NO_E_CODE    = 4'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_exception_code_f,
    input  logic [3:0]  i_exception_code_e,
    input  logic [31:0] i_pc_f,
    input  logic [31:0] i_pc_e,
    input  logic [31:0] i_alu_out_e,
    input  logic        i_mret_e,
    output logic        o_pc_redirect_en,
    output logic [31:0] o_pc_redirect,
    output logic        o_flush,
    output logic        o_trap_permission,
    output logic        o_reset_permission,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mcause,
    output logic [31:0] o_mtval,
    output logic        o_halt,
    output logic [31:0] o_trap_count
);
    typedef enum logic [2:0] {RST_HDL, RUN, FLUSH, HANDLER, RETURN, LOCKUP} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mepc_q, mepc_d, mtval_q, mtval_d;
    logic [3:0]  mcause_q, mcause_d;
    logic        rst_perm_q, rst_perm_d;
    logic        sel_e, exc;
    assign sel_e = i_exception_code_e != NO_E_CODE;
    assign exc   = sel_e || (i_exception_code_f != NO_E_CODE);
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mepc_d     = mepc_q;
        mtval_d    = mtval_q;
        mcause_d   = mcause_q;
        rst_perm_d = rst_perm_q;
        case (state_q)
            RST_HDL: begin
                if (exc) state_d = LOCKUP;
                else if (i_mret_e) begin
                    state_d    = RETURN;
                    rst_perm_d = 1'b0;
                end
            end
            RUN: begin
                if (exc) begin
                    state_d  = FLUSH;
                    cnt_d    = 3'(FLUSH_CYCLES);
                    mepc_d   = sel_e ? i_pc_e : i_pc_f;
                    mtval_d  = sel_e ? i_alu_out_e : i_pc_f;
                    mcause_d = sel_e ? i_exception_code_e : i_exception_code_f;
                end
            end
            FLUSH: begin
                cnt_d   = cnt_q - 3'd1;
                state_d = (cnt_q == 3'd1) ? HANDLER : FLUSH;
            end
            HANDLER: state_d = exc ? LOCKUP : (i_mret_e ? RETURN : HANDLER);
            RETURN:  state_d = RUN;
            default: state_d = LOCKUP;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RST_HDL;
            cnt_q      <= 3'd0;
            mepc_q     <= TEXT_BASE;
            mtval_q    <= 32'h0;
            mcause_q   <= 4'h0;
            rst_perm_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mepc_q     <= mepc_d;
            mtval_q    <= mtval_d;
            mcause_q   <= mcause_d;
            rst_perm_q <= rst_perm_d;
        end
    end
    // outputs decode purely from flops, so they change only on clock or reset
    assign o_pc_redirect_en   = (state_q == RETURN) || (state_q == FLUSH && cnt_q == 3'(FLUSH_CYCLES));
    assign o_pc_redirect      = (state_q == RETURN) ? mepc_q : (o_pc_redirect_en ? TRAP_VECTOR : 32'h0);
    assign o_flush            = (state_q == FLUSH) || (state_q == RETURN) || (state_q == LOCKUP);
    assign o_trap_permission  = state_q == HANDLER;
    assign o_reset_permission = rst_perm_q;
    assign o_halt             = state_q == LOCKUP;
    assign o_mepc             = mepc_q;
    assign o_mcause           = {28'b0, mcause_q};
    assign o_mtval            = mtval_q;
`ifdef TRAP_COUNT_EN
    logic [31:0] count_q, count_d;
    always_comb count_d = count_q + 32'((state_q == RUN) && exc);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) count_q <= 32'h0;
        else count_q <= count_d;
    end
    assign o_trap_count = count_q;
`else
    assign o_trap_count = 32'h0;
`endif
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed checks of trap entry, return, double fault and reset
module tb_trap_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  code_f, code_e;
    logic [31:0] pc_f, pc_e, alu;
    logic        mret;
    logic        redir_en, flush, trap_perm, rst_perm, halt;
    logic [31:0] redir, mepc, mcause, mtval, trap_cnt;
    int          errors = 0;
    int          checks = 0;
`ifdef TRAP_COUNT_EN
    localparam logic [31:0] EXP_CNT = 32'd3;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif
    always #5 clk = ~clk;
    trap_controller dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_exception_code_f(code_f), .i_exception_code_e(code_e),
        .i_pc_f(pc_f), .i_pc_e(pc_e), .i_alu_out_e(alu), .i_mret_e(mret),
        .o_pc_redirect_en(redir_en), .o_pc_redirect(redir), .o_flush(flush),
        .o_trap_permission(trap_perm), .o_reset_permission(rst_perm),
        .o_mepc(mepc), .o_mcause(mcause), .o_mtval(mtval),
        .o_halt(halt), .o_trap_count(trap_cnt)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic idle();
        code_f = 4'h0;
        code_e = 4'h0;
        mret   = 1'b0;
    endtask
    task automatic chk_out(input string tag, input logic re, input logic [31:0] r, input logic fl,
                           input logic tp, input logic ha);
        chk({tag, ".redir_en"}, 32'(redir_en), 32'(re));
        chk({tag, ".redir"}, redir, r);
        chk({tag, ".flush"}, 32'(flush), 32'(fl));
        chk({tag, ".trap_perm"}, 32'(trap_perm), 32'(tp));
        chk({tag, ".halt"}, 32'(halt), 32'(ha));
    endtask
    task automatic chk_csr(input string tag, input logic [31:0] ep, input logic [31:0] ca,
                           input logic [31:0] tv);
        chk({tag, ".mepc"}, mepc, ep);
        chk({tag, ".mcause"}, mcause, ca);
        chk({tag, ".mtval"}, mtval, tv);
    endtask
    task automatic do_return(input string tag, input logic [31:0] target);
        mret = 1'b1;
        step();
        idle();
        chk_out({tag, ".ret"}, 1'b1, target, 1'b1, 1'b0, 1'b0);
        step();
        chk_out({tag, ".run"}, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic trap_entry(input string tag, input logic [31:0] ep, input logic [31:0] ca,
                              input logic [31:0] tv);
        step();
        idle();
        chk_csr(tag, ep, ca, tv);
        chk_out({tag, ".f1"}, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out({tag, ".f2"}, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_out({tag, ".hdl"}, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask
    initial begin
        rst_n = 1'b0;
        idle();
        pc_f = 32'h0;
        pc_e = 32'h0;
        alu  = 32'h0;
        repeat (2) step();
        chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_csr("rst", 32'h0008_0000, 32'h0, 32'h0);
        chk("rst.rst_perm", 32'(rst_perm), 32'h1);
        chk("rst.count", trap_cnt, 32'h0);
        rst_n = 1'b1;
        step();
        chk_out("rsthdl", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        do_return("boot", 32'h0008_0000);
        chk("boot.rst_perm", 32'(rst_perm), 32'h0);
        code_e = 4'h4;
        pc_e   = 32'h0008_0010;
        alu    = 32'h0010_0002;
        trap_entry("t1", 32'h0008_0010, 32'h4, 32'h0010_0002);
        do_return("t1", 32'h0008_0010);
        chk("t1.rst_perm", 32'(rst_perm), 32'h0);
        code_f = 4'h1;
        code_e = 4'h6;
        pc_f   = 32'h0008_0020;
        pc_e   = 32'h0008_0030;
        alu    = 32'h0000_0055;
        trap_entry("t2", 32'h0008_0030, 32'h6, 32'h0000_0055);
        do_return("t2", 32'h0008_0030);
        code_f = 4'h2;
        pc_f   = 32'h0008_0040;
        trap_entry("t3", 32'h0008_0040, 32'h2, 32'h0008_0040);
        chk("t3.count", trap_cnt, EXP_CNT);
        mret   = 1'b1;
        code_e = 4'h5;
        pc_e   = 32'h0000_dead;
        alu    = 32'h0000_beef;
        step();
        idle();
        chk_out("dbl", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk_csr("dbl", 32'h0008_0040, 32'h2, 32'h0008_0040);
        chk("dbl.count", trap_cnt, EXP_CNT);
        mret = 1'b1;
        repeat (4) step();
        idle();
        chk_out("lock", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_csr("arst", 32'h0008_0000, 32'h0, 32'h0);
        chk("arst.rst_perm", 32'(rst_perm), 32'h1);
        chk("arst.count", trap_cnt, 32'h0);
        step();
        rst_n  = 1'b1;
        code_f = 4'h3;
        step();
        idle();
        chk_out("rstexc", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("rstexc.count", trap_cnt, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
